// File: rtl/com2_sched_if.sv
// com2_sched_if: link and requester signals of the com2 round-robin scheduler.
//   slave  modport - the scheduler (com2_sched)
//   master modport - the environment: com2 UART registers plus user requesters
//   FRAME_STB, DATA_IN0/1      com2 -> scheduler (frame done, inbound tag/payload)
//   DATA_OUT0/1                scheduler -> com2 (outbound tag/payload)
//   REQ, REQ_DATA / GNT        requester handshake (level request, one-cycle grant)
//   RX_VALID, RX_DATA          inbound demux to requesters
//   BAD_CNT, LINK_ERR          status
interface com2_sched_if;
    logic        FRAME_STB;
    logic [7:0]  DATA_IN0;
    logic [7:0]  DATA_IN1;
    logic [7:0]  DATA_OUT0;
    logic [7:0]  DATA_OUT1;
    logic [3:0]  REQ;
    logic [31:0] REQ_DATA;
    logic [3:0]  GNT;
    logic [3:0]  RX_VALID;
    logic [7:0]  RX_DATA;
    logic [7:0]  BAD_CNT;
    logic        LINK_ERR;

    modport slave (
        input  FRAME_STB, DATA_IN0, DATA_IN1, REQ, REQ_DATA,
        output DATA_OUT0, DATA_OUT1, GNT, RX_VALID, RX_DATA, BAD_CNT, LINK_ERR
    );

    modport master (
        output FRAME_STB, DATA_IN0, DATA_IN1, REQ, REQ_DATA,
        input  DATA_OUT0, DATA_OUT1, GNT, RX_VALID, RX_DATA, BAD_CNT, LINK_ERR
    );
endinterface

// File: rtl/com2_sched.sv
// com2_sched: shares the two-byte com2 frame link among four requesters.
// Outbound: round-robin picks one requester in IDLE, latches its tagged byte
// onto DATA_OUT0/1 and holds it until com2 reports the frame done, then
// pulses GNT. Inbound: every completed frame with a valid, well-formed tag is
// routed to RX_VALID[channel]; malformed tags are counted in BAD_CNT.
// A watchdog raises sticky LINK_ERR if a loaded frame waits TIMEOUT cycles.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - com2_sched_if.slave (link, requester and status signals)
module com2_sched #(
    parameter int TIMEOUT = 100000
) (
    input  logic         CLK,
    input  logic         RST,
    com2_sched_if.slave  bus
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    typedef enum logic {IDLE, LOADED} state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [1:0]      owner;
    logic [7:0]      data_out0;
    logic [7:0]      data_out1;
    logic [3:0]      gnt;
    logic [3:0]      rx_valid;
    logic [7:0]      rx_data;
    logic [7:0]      bad_cnt;
    logic            link_err;
    logic [WD_W-1:0] wd_cnt;

    logic            found;
    logic [1:0]      win;

    // Round-robin search starting at ptr; 2-bit index wraps 3->0 naturally.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 0; i < 4; i++) begin
            if (!found && bus.REQ[ptr + 2'(i)]) begin
                found = 1'b1;
                win   = ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            data_out0 <= 8'h00;
            data_out1 <= 8'h00;
            gnt       <= 4'b0000;
            rx_valid  <= 4'b0000;
            rx_data   <= 8'h00;
            bad_cnt   <= 8'h00;
            link_err  <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            gnt      <= 4'b0000;
            rx_valid <= 4'b0000;

            // Inbound demux runs in either state; tag bit 7 clear is an idle frame.
            if (bus.FRAME_STB && bus.DATA_IN0[7]) begin
                if (bus.DATA_IN0[6:2] == 5'd0) begin
                    rx_valid <= 4'b0001 << bus.DATA_IN0[1:0];
                    rx_data  <= bus.DATA_IN1;
                end else if (bad_cnt != 8'hFF) begin
                    bad_cnt <= bad_cnt + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    // A strobe here only completes the idle frame; loading still proceeds.
                    if (found) begin
                        data_out0 <= {1'b1, 5'b00000, win};
                        data_out1 <= bus.REQ_DATA[{win, 3'b000} +: 8];
                        owner     <= win;
                        wd_cnt    <= '0;
                        state     <= LOADED;
                    end
                end
                LOADED: begin
                    if (bus.FRAME_STB) begin
                        gnt       <= 4'b0001 << owner;
                        ptr       <= owner + 2'd1;
                        data_out0 <= 8'h00;
                        data_out1 <= 8'h00;
                        wd_cnt    <= '0;
                        state     <= IDLE;
                    end else begin
                        // Keep waiting after the error; counter parks at TIMEOUT.
                        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == WD_LAST) link_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DATA_OUT0 = data_out0;
    assign bus.DATA_OUT1 = data_out1;
    assign bus.GNT       = gnt;
    assign bus.RX_VALID  = rx_valid;
    assign bus.RX_DATA   = rx_data;
    assign bus.BAD_CNT   = bad_cnt;
    assign bus.LINK_ERR  = link_err;
endmodule

// File: tb/tb_com2_sched.sv
module tb_com2_sched;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    com2_sched_if bus();
    com2_sched #(.TIMEOUT(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] rxv;
        logic [7:0] rxd;
    } exp_t;

    exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Drive a one-cycle FRAME_STB from a negedge; returns at the negedge after
    // the strobe edge, where GNT/RX_VALID for that frame are visible.
    task automatic pulse_stb(input logic [7:0] in0, input logic [7:0] in1);
        bus.FRAME_STB = 1'b1;
        bus.DATA_IN0  = in0;
        bus.DATA_IN1  = in1;
        @(posedge CLK);
        @(negedge CLK);
        bus.FRAME_STB = 1'b0;
        bus.DATA_IN0  = 8'h00;
        bus.DATA_IN1  = 8'h00;
    endtask

    task automatic rst_pulse();
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        bus.FRAME_STB = 1'b0;
        bus.DATA_IN0  = 8'h00;
        bus.DATA_IN1  = 8'h00;
        bus.REQ       = 4'b0000;
        bus.REQ_DATA  = 32'h0;
        repeat (2) @(negedge CLK);
        rst_pulse();
        n_vec++; if (bus.DATA_OUT0 !== 8'h00) begin n_err++; $display("FAIL rst_out0 got %h exp 00", bus.DATA_OUT0); end
        n_vec++; if (bus.DATA_OUT1 !== 8'h00) begin n_err++; $display("FAIL rst_out1 got %h exp 00", bus.DATA_OUT1); end
        n_vec++; if (bus.GNT !== 4'b0000) begin n_err++; $display("FAIL rst_gnt got %b exp 0000", bus.GNT); end
        n_vec++; if (bus.RX_VALID !== 4'b0000) begin n_err++; $display("FAIL rst_rxv got %b exp 0000", bus.RX_VALID); end
        n_vec++; if (bus.RX_DATA !== 8'h00) begin n_err++; $display("FAIL rst_rxd got %h exp 00", bus.RX_DATA); end
        n_vec++; if (bus.BAD_CNT !== 8'h00) begin n_err++; $display("FAIL rst_bad got %h exp 00", bus.BAD_CNT); end
        n_vec++; if (bus.LINK_ERR !== 1'b0) begin n_err++; $display("FAIL rst_lerr got %b exp 0", bus.LINK_ERR); end
    endtask

    task automatic test_single();
        exp_t e;
        bus.REQ      = 4'b0100;
        bus.REQ_DATA = 32'h00A5_0000;
        @(posedge CLK); @(negedge CLK);
        bus.REQ = 4'b0000;
        n_vec++; if (bus.DATA_OUT0 !== 8'h82) begin n_err++; $display("FAIL single_out0 got %h exp 82", bus.DATA_OUT0); end
        n_vec++; if (bus.DATA_OUT1 !== 8'hA5) begin n_err++; $display("FAIL single_out1 got %h exp a5", bus.DATA_OUT1); end
        exp_q.push_back('{gnt: 4'b0100, rxv: 4'b0000, rxd: 8'h00});
        pulse_stb(8'h00, 8'h00);
        e = exp_q.pop_front();
        n_vec++; if (bus.GNT !== e.gnt) begin n_err++; $display("FAIL single_gnt got %b exp %b", bus.GNT, e.gnt); end
        n_vec++; if (bus.DATA_OUT0 !== 8'h00) begin n_err++; $display("FAIL single_out0_clr got %h exp 00", bus.DATA_OUT0); end
        @(negedge CLK);
        n_vec++; if (bus.GNT !== 4'b0000) begin n_err++; $display("FAIL single_gnt_once got %b exp 0000", bus.GNT); end
    endtask

    task automatic test_fairness();
        exp_t e;
        logic [1:0] order [12];
        logic [1:0] id;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
        rst_pulse();
        bus.REQ      = 4'b1111;
        bus.REQ_DATA = 32'h4433_2211;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) bus.REQ = 4'b1001;
            @(posedge CLK); @(negedge CLK);
            id = order[k];
            n_vec++;
            if (bus.DATA_OUT0 !== {6'b100000, id}) begin
                n_err++; $display("FAIL fair_tag[%0d] got %h exp %h", k, bus.DATA_OUT0, {6'b100000, id});
            end
            exp_q.push_back('{gnt: 4'b0001 << id, rxv: 4'b0000, rxd: 8'h00});
            pulse_stb(8'h00, 8'h00);
            e = exp_q.pop_front();
            n_vec++;
            if (bus.GNT !== e.gnt) begin
                n_err++; $display("FAIL fair_gnt[%0d] got %b exp %b", k, bus.GNT, e.gnt);
            end
        end
        bus.REQ = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_inbound();
        exp_t e;
        logic [7:0] exp_bad;
        logic [7:0] last_rxd;
        logic [7:0] in0 [4];
        logic [7:0] in1 [4];
        in0 = '{8'h83, 8'h84, 8'h00, 8'h80};
        in1 = '{8'h3C, 8'h99, 8'h55, 8'h11};
        exp_bad  = 8'h00;
        last_rxd = bus.RX_DATA;
        rst_pulse();
        last_rxd = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (in0[k][7] && in0[k][6:2] == 5'd0) begin
                exp_q.push_back('{gnt: 4'b0000, rxv: 4'b0001 << in0[k][1:0], rxd: in1[k]});
                last_rxd = in1[k];
            end else begin
                exp_q.push_back('{gnt: 4'b0000, rxv: 4'b0000, rxd: last_rxd});
                if (in0[k][7]) exp_bad++;
            end
            pulse_stb(in0[k], in1[k]);
            e = exp_q.pop_front();
            n_vec++; if (bus.RX_VALID !== e.rxv) begin n_err++; $display("FAIL in_rxv[%0d] got %b exp %b", k, bus.RX_VALID, e.rxv); end
            n_vec++; if (bus.RX_DATA !== e.rxd) begin n_err++; $display("FAIL in_rxd[%0d] got %h exp %h", k, bus.RX_DATA, e.rxd); end
            n_vec++; if (bus.BAD_CNT !== exp_bad) begin n_err++; $display("FAIL in_bad[%0d] got %h exp %h", k, bus.BAD_CNT, exp_bad); end
        end
        for (int k = 0; k < 300; k++) pulse_stb(8'hFC, 8'h00);
        n_vec++; if (bus.BAD_CNT !== 8'hFF) begin n_err++; $display("FAIL in_bad_sat got %h exp ff", bus.BAD_CNT); end
        n_vec++; if (bus.RX_DATA !== 8'h11) begin n_err++; $display("FAIL in_rxd_hold got %h exp 11", bus.RX_DATA); end
    endtask

    task automatic test_watchdog();
        exp_t e;
        rst_pulse();
        bus.REQ      = 4'b0010;
        bus.REQ_DATA = 32'h0000_5A00;
        @(posedge CLK); @(negedge CLK);
        bus.REQ = 4'b0000;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); @(negedge CLK);
            if (c == 15) begin
                n_vec++; if (bus.LINK_ERR !== 1'b0) begin n_err++; $display("FAIL wd_early got %b exp 0", bus.LINK_ERR); end
            end
            if (c == 16) begin
                n_vec++; if (bus.LINK_ERR !== 1'b1) begin n_err++; $display("FAIL wd_set got %b exp 1", bus.LINK_ERR); end
            end
        end
        n_vec++; if (bus.DATA_OUT0 !== 8'h81) begin n_err++; $display("FAIL wd_hold0 got %h exp 81", bus.DATA_OUT0); end
        n_vec++; if (bus.DATA_OUT1 !== 8'h5A) begin n_err++; $display("FAIL wd_hold1 got %h exp 5a", bus.DATA_OUT1); end
        // Grant and inbound delivery land in the same cycle.
        exp_q.push_back('{gnt: 4'b0010, rxv: 4'b0010, rxd: 8'h77});
        pulse_stb(8'h81, 8'h77);
        e = exp_q.pop_front();
        n_vec++; if (bus.GNT !== e.gnt) begin n_err++; $display("FAIL wd_gnt got %b exp %b", bus.GNT, e.gnt); end
        n_vec++; if (bus.RX_VALID !== e.rxv) begin n_err++; $display("FAIL wd_rxv got %b exp %b", bus.RX_VALID, e.rxv); end
        n_vec++; if (bus.RX_DATA !== e.rxd) begin n_err++; $display("FAIL wd_rxd got %h exp %h", bus.RX_DATA, e.rxd); end
        n_vec++; if (bus.LINK_ERR !== 1'b1) begin n_err++; $display("FAIL wd_sticky got %b exp 1", bus.LINK_ERR); end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        bus.REQ      = 4'b0010;
        bus.REQ_DATA = 32'hDDCC_BBAA;
        @(posedge CLK); @(negedge CLK);
        n_vec++; if (bus.DATA_OUT0 !== 8'h81) begin n_err++; $display("FAIL rmf_load got %h exp 81", bus.DATA_OUT0); end
        bus.REQ = 4'b0000;
        rst_pulse();
        n_vec++; if (bus.DATA_OUT0 !== 8'h00) begin n_err++; $display("FAIL rmf_out0 got %h exp 00", bus.DATA_OUT0); end
        n_vec++; if (bus.DATA_OUT1 !== 8'h00) begin n_err++; $display("FAIL rmf_out1 got %h exp 00", bus.DATA_OUT1); end
        n_vec++; if (bus.LINK_ERR !== 1'b0) begin n_err++; $display("FAIL rmf_lerr got %b exp 0", bus.LINK_ERR); end
        exp_q.push_back('{gnt: 4'b0000, rxv: 4'b0000, rxd: 8'h00});
        pulse_stb(8'h00, 8'h00);
        e = exp_q.pop_front();
        n_vec++; if (bus.GNT !== e.gnt) begin n_err++; $display("FAIL rmf_nognt got %b exp %b", bus.GNT, e.gnt); end
        bus.REQ = 4'b1111;
        @(posedge CLK); @(negedge CLK);
        n_vec++; if (bus.DATA_OUT0 !== 8'h80) begin n_err++; $display("FAIL rmf_ptr0 got %h exp 80", bus.DATA_OUT0); end
        exp_q.push_back('{gnt: 4'b0001, rxv: 4'b0000, rxd: 8'h00});
        pulse_stb(8'h00, 8'h00);
        bus.REQ = 4'b0000;
        e = exp_q.pop_front();
        n_vec++; if (bus.GNT !== e.gnt) begin n_err++; $display("FAIL rmf_gnt got %b exp %b", bus.GNT, e.gnt); end
    endtask

    task automatic test_withdrawn();
        exp_t e;
        @(negedge CLK);
        // Strobe coincides with the load edge: idle-frame completion, load proceeds.
        bus.REQ      = 4'b0100;
        bus.REQ_DATA = 32'h00C3_0000;
        exp_q.push_back('{gnt: 4'b0000, rxv: 4'b0000, rxd: 8'h00});
        pulse_stb(8'h00, 8'h00);
        bus.REQ      = 4'b0000;
        bus.REQ_DATA = 32'hFFFF_FFFF;
        e = exp_q.pop_front();
        n_vec++; if (bus.GNT !== e.gnt) begin n_err++; $display("FAIL wdr_idle_gnt got %b exp %b", bus.GNT, e.gnt); end
        repeat (3) @(negedge CLK);
        n_vec++; if (bus.DATA_OUT0 !== 8'h82) begin n_err++; $display("FAIL wdr_out0 got %h exp 82", bus.DATA_OUT0); end
        n_vec++; if (bus.DATA_OUT1 !== 8'hC3) begin n_err++; $display("FAIL wdr_out1 got %h exp c3", bus.DATA_OUT1); end
        exp_q.push_back('{gnt: 4'b0100, rxv: 4'b0000, rxd: 8'h00});
        pulse_stb(8'h00, 8'h00);
        e = exp_q.pop_front();
        n_vec++; if (bus.GNT !== e.gnt) begin n_err++; $display("FAIL wdr_gnt got %b exp %b", bus.GNT, e.gnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_inbound();
        test_watchdog();
        test_reset_mid_frame();
        test_withdrawn();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
